// File: rtl/ttt_pkg.sv
// ----------------------------------------------------------------------------
// ttt_pkg
// Shared definitions for the ttt event path.
//   TS_*          : start/stop codes as produced by the core (bit1 = start,
//                   bit0 = stop).
//   ttt_event_t   : one buffered event for the default configuration
//                   (10 processors, 8-bit timestamp when
//                   TTT_EVENT_TIMESTAMP_EN is defined).
//   is_event()    : a code of TS_NONE carries no information and is dropped
//                   silently before it reaches the FIFO.
// ----------------------------------------------------------------------------
package ttt_pkg;

    localparam logic [1:0] TS_NONE  = 2'b00;
    localparam logic [1:0] TS_STOP  = 2'b01;
    localparam logic [1:0] TS_START = 2'b10;
    localparam logic [1:0] TS_BOTH  = 2'b11;

    localparam int TTT_NUM_PROCESSORS = 10;
    localparam int TTT_ID_W           = $clog2(TTT_NUM_PROCESSORS);
    localparam int TTT_TS_W           = 8;

    typedef struct packed {
        logic [TTT_ID_W-1:0] id;
        logic [1:0]          code;
`ifdef TTT_EVENT_TIMESTAMP_EN
        logic [TTT_TS_W-1:0] ts;
`endif
    } ttt_event_t;

    function automatic logic is_event(input logic [1:0] code);
        return code != TS_NONE;
    endfunction

endpackage

// File: rtl/ttt_event_fifo_if.sv
// ----------------------------------------------------------------------------
// ttt_event_fifo_if
// Bundles both sides of the event buffer.
//   Capture side (from core): event_valid_in, processor_id_in,
//                             token_startstop_in
//   Drain side (to serializer): event_valid_out, event_ready_in,
//                             processor_id_out, token_startstop_out,
//                             timestamp_out (only with TTT_EVENT_TIMESTAMP_EN)
//   Status: fifo_count, dropped_count, overflow
// Modports: slave = the buffer itself, master = its environment.
// ----------------------------------------------------------------------------
interface ttt_event_fifo_if #(
    parameter int NUM_PROCESSORS = 10,
    parameter int FIFO_DEPTH     = 4,
    parameter int DROP_BITS      = 8,
    parameter int TIMESTAMP_BITS = 8
);
    localparam int ID_W  = $clog2(NUM_PROCESSORS);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                      event_valid_in;
    logic [ID_W-1:0]           processor_id_in;
    logic [1:0]                token_startstop_in;
    logic                      event_valid_out;
    logic                      event_ready_in;
    logic [ID_W-1:0]           processor_id_out;
    logic [1:0]                token_startstop_out;
`ifdef TTT_EVENT_TIMESTAMP_EN
    logic [TIMESTAMP_BITS-1:0] timestamp_out;
`endif
    logic [CNT_W-1:0]          fifo_count;
    logic [DROP_BITS-1:0]      dropped_count;
    logic                      overflow;

    modport slave (
        input  event_valid_in, processor_id_in, token_startstop_in, event_ready_in,
        output event_valid_out, processor_id_out, token_startstop_out,
               fifo_count, dropped_count, overflow
`ifdef TTT_EVENT_TIMESTAMP_EN
        , output timestamp_out
`endif
    );

    modport master (
        output event_valid_in, processor_id_in, token_startstop_in, event_ready_in,
        input  event_valid_out, processor_id_out, token_startstop_out,
               fifo_count, dropped_count, overflow
`ifdef TTT_EVENT_TIMESTAMP_EN
        , input timestamp_out
`endif
    );

endinterface

// File: rtl/ttt_sync_fifo.sv
// ----------------------------------------------------------------------------
// ttt_sync_fifo
// Generic single-clock FIFO, DEPTH must be a power of two >= 2.
//   clk, rst   : clock, synchronous active-high reset (control state only)
//   wr_en      : write request; honoured when not full or when a read is
//                taken in the same cycle
//   wr_accept  : wr_en was honoured this cycle
//   rd_en      : read request; ignored while empty
//   wdata      : write payload
//   rdata      : payload at the read pointer (stale when empty)
//   count      : occupancy 0..DEPTH
//   full/empty : decoded from count, not from the pointers
// ----------------------------------------------------------------------------
module ttt_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    output logic                   wr_accept,
    input  logic                   rd_en,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             rd_ok;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign rd_ok     = rd_en && !empty;
    // A read in the same cycle frees the slot the write lands in.
    assign wr_accept = wr_en && (!full || rd_ok);
    assign rdata     = mem[rd_ptr];

    // Storage: data only, never reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Control: pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok)     rd_ptr <= rd_ptr + 1'b1;
            case ({wr_accept, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ttt_event_fifo.sv
// ----------------------------------------------------------------------------
// ttt_event_fifo
// Output event buffer behind the ttt core. Every start/stop event the core
// emits is captured in the cycle it appears (the core cannot be stalled),
// queued, and offered to the pin serializer over valid/ready. Events that
// find the queue full are counted in dropped_count and flag overflow.
//
// Ports:
//   clock_fast : sole clock, rising edge
//   reset      : synchronous, active-high
//   bus        : ttt_event_fifo_if.slave (capture inputs, drain outputs,
//                fifo_count, dropped_count, overflow)
//
// Build option: define TTT_EVENT_TIMESTAMP_EN to tag each entry with a
// free-running TIMESTAMP_BITS cycle counter and expose it on
// bus.timestamp_out.
// ----------------------------------------------------------------------------
module ttt_event_fifo
    import ttt_pkg::*;
#(
    parameter int NUM_PROCESSORS = 10,
    parameter int FIFO_DEPTH     = 4,
    parameter int DROP_BITS      = 8,
    parameter int TIMESTAMP_BITS = 8
) (
    input  logic           clock_fast,
    input  logic           reset,
    ttt_event_fifo_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_PROCESSORS);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [ID_W-1:0]           id;
        logic [1:0]                code;
`ifdef TTT_EVENT_TIMESTAMP_EN
        logic [TIMESTAMP_BITS-1:0] ts;
`endif
    } ev_t;

    localparam int PAYLOAD_W = $bits(ev_t);

    ev_t                  wr_ev;
    ev_t                  rd_ev;
    logic [PAYLOAD_W-1:0] rdata;
    logic                 push_req;
    logic                 push_ok;
    logic                 pop;
    logic                 drop;
    logic                 full;
    logic                 empty;
    logic [CNT_W-1:0]     count;
    logic [DROP_BITS-1:0] drop_cnt;
    logic                 ovf;

`ifdef TTT_EVENT_TIMESTAMP_EN
    logic [TIMESTAMP_BITS-1:0] ts_cnt;

    always_ff @(posedge clock_fast) begin
        if (reset) ts_cnt <= '0;
        else       ts_cnt <= ts_cnt + 1'b1;
    end
`endif

    // Capture stage: qualify the core's event and build the entry.
    assign push_req   = bus.event_valid_in && is_event(bus.token_startstop_in);
    assign pop        = bus.event_valid_out && bus.event_ready_in;
    assign drop       = push_req && !push_ok;

    always_comb begin
        wr_ev      = '0;
        wr_ev.id   = bus.processor_id_in;
        wr_ev.code = bus.token_startstop_in;
`ifdef TTT_EVENT_TIMESTAMP_EN
        wr_ev.ts   = ts_cnt;
`endif
    end

    ttt_sync_fifo #(
        .WIDTH (PAYLOAD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clock_fast),
        .rst       (reset),
        .wr_en     (push_req),
        .wr_accept (push_ok),
        .rd_en     (pop),
        .wdata     (wr_ev),
        .rdata     (rdata),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Drop accounting: saturating, cleared only by reset.
    always_ff @(posedge clock_fast) begin
        if (reset) begin
            drop_cnt <= '0;
            ovf      <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // Drain stage: head entry, zeroed while empty so the pins stay quiet.
    assign rd_ev                   = ev_t'(rdata);
    assign bus.event_valid_out     = !empty;
    assign bus.processor_id_out    = empty ? '0 : rd_ev.id;
    assign bus.token_startstop_out = empty ? '0 : rd_ev.code;
`ifdef TTT_EVENT_TIMESTAMP_EN
    assign bus.timestamp_out       = empty ? '0 : rd_ev.ts;
`endif
    assign bus.fifo_count          = count;
    assign bus.dropped_count       = drop_cnt;
    assign bus.overflow            = ovf;

    // full is only consumed inside the FIFO's accept decision.
    logic unused_full;
    assign unused_full = full;

endmodule

// File: tb/tb_ttt_event_fifo.sv
// ----------------------------------------------------------------------------
// tb_ttt_event_fifo
// Directed bench for ttt_event_fifo (depth 4, 10 processors, 8-bit drop
// counter). A table of per-cycle stimulus/expectation records covers fill,
// overflow, full push+pop, ignored code 00 and drain; hand-written sequences
// cover reset, mid-operation reset, sustained streaming, counter saturation
// and (with TTT_EVENT_TIMESTAMP_EN) timestamps.
// ----------------------------------------------------------------------------
module tb_ttt_event_fifo;
    import ttt_pkg::*;

    localparam int NP = 10;
    localparam int FD = 4;
    localparam int DB = 8;
    localparam int TB = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ttt_event_fifo_if #(
        .NUM_PROCESSORS (NP),
        .FIFO_DEPTH     (FD),
        .DROP_BITS      (DB),
        .TIMESTAMP_BITS (TB)
    ) bus ();

    ttt_event_fifo #(
        .NUM_PROCESSORS (NP),
        .FIFO_DEPTH     (FD),
        .DROP_BITS      (DB),
        .TIMESTAMP_BITS (TB)
    ) dut (
        .clock_fast (clk),
        .reset      (rst),
        .bus        (bus)
    );

    typedef struct {
        int vin;
        int id;
        int code;
        int rdy;
        int evld;
        int eid;
        int ecode;
        int ecnt;
        int edrop;
        int eovf;
    } vec_t;

    vec_t vecs [15];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic drive(input int vin, input int id, input int code, input int rdy);
        bus.event_valid_in     = vin[0];
        bus.processor_id_in    = id[3:0];
        bus.token_startstop_in = code[1:0];
        bus.event_ready_in     = rdy[0];
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int evld, input int eid, input int ecode,
                             input int ecnt, input int edrop, input int eovf);
        check({tag, " valid"}, int'(bus.event_valid_out), evld);
        check({tag, " id"},    int'(bus.processor_id_out), eid);
        check({tag, " code"},  int'(bus.token_startstop_out), ecode);
        check({tag, " count"}, int'(bus.fifo_count), ecnt);
        check({tag, " drop"},  int'(bus.dropped_count), edrop);
        check({tag, " ovf"},   int'(bus.overflow), eovf);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //              vin id code       rdy  evld eid ecode     cnt drop ovf
        vecs[0]  = '{1, 3, TS_START, 0,  1, 3, TS_START, 1, 0, 0};
        vecs[1]  = '{1, 5, TS_STOP,  0,  1, 3, TS_START, 2, 0, 0};
        vecs[2]  = '{1, 7, TS_BOTH,  0,  1, 3, TS_START, 3, 0, 0};
        vecs[3]  = '{1, 1, TS_START, 0,  1, 3, TS_START, 4, 0, 0};
        vecs[4]  = '{1, 2, TS_STOP,  0,  1, 3, TS_START, 4, 1, 1};
        vecs[5]  = '{1, 4, TS_START, 0,  1, 3, TS_START, 4, 2, 1};
        vecs[6]  = '{1, 0, TS_NONE,  0,  1, 3, TS_START, 4, 2, 1};
        vecs[7]  = '{1, 9, TS_START, 1,  1, 5, TS_STOP,  4, 2, 1};
        vecs[8]  = '{0, 0, TS_NONE,  1,  1, 7, TS_BOTH,  3, 2, 1};
        vecs[9]  = '{0, 0, TS_NONE,  1,  1, 1, TS_START, 2, 2, 1};
        vecs[10] = '{0, 0, TS_NONE,  1,  1, 9, TS_START, 1, 2, 1};
        vecs[11] = '{1, 6, TS_STOP,  1,  1, 6, TS_STOP,  1, 2, 1};
        vecs[12] = '{0, 0, TS_NONE,  1,  0, 0, 0,        0, 2, 1};
        vecs[13] = '{1, 0, TS_NONE,  0,  0, 0, 0,        0, 2, 1};
        vecs[14] = '{0, 0, TS_NONE,  1,  0, 0, 0,        0, 2, 1};

        // Reset, with an event presented during the reset cycle.
        rst = 1'b1;
        drive(0, 0, 0, 0);
        drive(1, 3, TS_START, 0);
        check_all("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Table-driven fill / overflow / full push+pop / drain.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].vin, vecs[i].id, vecs[i].code, vecs[i].rdy);
            check_all($sformatf("vec%0d", i), vecs[i].evld, vecs[i].eid, vecs[i].ecode,
                      vecs[i].ecnt, vecs[i].edrop, vecs[i].eovf);
        end

        // Mid-operation reset discards entries and clears drop state.
        drive(1, 2, TS_START, 0);
        check("midrst pre count", int'(bus.fifo_count), 1);
        rst = 1'b1;
        drive(1, 8, TS_STOP, 0);
        check_all("midrst", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        drive(0, 0, 0, 0);
        check("midrst post count", int'(bus.fifo_count), 0);

        // Sustained streaming with ready held high: pointers wrap, count stays 1.
        for (int k = 0; k < 20; k++) begin
            ttt_event_t ev;
            ev.id   = 4'(k % 10);
            ev.code = 2'((k % 3) + 1);
            drive(1, int'(ev.id), int'(ev.code), 1);
            check($sformatf("stream%0d valid", k), int'(bus.event_valid_out), 1);
            check($sformatf("stream%0d id", k),    int'(bus.processor_id_out), int'(ev.id));
            check($sformatf("stream%0d code", k),  int'(bus.token_startstop_out), int'(ev.code));
            check($sformatf("stream%0d count", k), int'(bus.fifo_count), 1);
        end
        drive(0, 0, 0, 1);
        check_all("stream end", 0, 0, 0, 0, 0, 0);

        // Drop counter saturation: 4 stored, 300 dropped.
        for (int i = 0; i < 304; i++) begin
            drive(1, i % 10, TS_STOP, 0);
            if (i == 257) check("sat 254", int'(bus.dropped_count), 254);
            if (i == 258) check("sat 255", int'(bus.dropped_count), 255);
        end
        check_all("sat end", 1, 0, TS_STOP, 4, 255, 1);

`ifdef TTT_EVENT_TIMESTAMP_EN
        // Timestamps: pushes in the cycles where the counter reads 2 and 5.
        rst = 1'b1;
        drive(0, 0, 0, 0);
        rst = 1'b0;
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(1, 4, TS_START, 0);
        check("ts first", int'(bus.timestamp_out), 2);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(1, 5, TS_STOP, 1);
        check("ts second", int'(bus.timestamp_out), 5);
        check("ts second id", int'(bus.processor_id_out), 5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
